// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame controller behind a byte receiver (header hunt, length, payload buffer, checksum, stream out)
// Ports: clk, rst_n (async, active-low); rx_data/rx_valid/rx_check_err/rx_stop_err from the byte receiver;
//        pay_data/pay_valid/pay_last/pay_ready payload stream; frame_len/frame_done on a good frame;
//        frame_err/err_code on an aborted frame or dropped byte.
// Optional: define RX_TIMEOUT_EN to abort a frame when no byte arrives within TIMEOUT_CYC cycles.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HDR0        = 8'hEB,
  parameter logic [7:0] HDR1        = 8'h90,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_check_err,
  input  logic       rx_stop_err,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic       pay_last,
  input  logic       pay_ready,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic [2:0] err_code
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CYC >= 1");
  end
  typedef enum logic [2:0] {IDLE, H1, LEN, PAY, CSUM, OUT} state_t;
  state_t        state;
  logic [7:0]    mem [MAX_LEN];
  logic [AW-1:0] idx, rd;
  logic [7:0]    len, csum;
  logic          bad, in_frame, tmo_hit;
  logic [2:0]    bad_code;
  assign bad      = rx_valid & (rx_check_err | rx_stop_err);
  assign bad_code = rx_check_err ? 3'd1 : 3'd2;
  assign in_frame = state inside {H1, LEN, PAY, CSUM};
`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo;
  // expiry is the TIMEOUT_CYC-th byte-free cycle; a byte in that cycle wins
  assign tmo_hit = in_frame & ~rx_valid & (tmo == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo <= '0;
    else tmo <= (in_frame & ~rx_valid & ~tmo_hit) ? tmo + 1'b1 : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk)
    if (state == PAY && rx_valid && !bad) mem[idx] <= rx_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      rd         <= '0;
      len        <= '0;
      csum       <= '0;
      pay_data   <= '0;
      pay_valid  <= 1'b0;
      pay_last   <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (tmo_hit) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        err_code  <= 3'd5;
      end else if (bad && in_frame) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        err_code  <= bad_code;
      end else begin
        case (state)
          IDLE: if (rx_valid && !bad && rx_data == HDR0) state <= H1;
          H1:   if (rx_valid) state <= rx_data == HDR1 ? LEN : rx_data == HDR0 ? H1 : IDLE;
          LEN:
            if (rx_valid) begin
              if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                err_code  <= 3'd3;
              end else begin
                len   <= rx_data;
                csum  <= rx_data;
                idx   <= '0;
                state <= PAY;
              end
            end
          PAY:
            if (rx_valid) begin
              csum <= csum + rx_data;
              idx  <= idx + 1'b1;
              if (8'(idx) == len - 8'd1) state <= CSUM;
            end
          CSUM:
            if (rx_valid) begin
              if (rx_data == csum) begin
                state      <= OUT;
                frame_len  <= len;
                frame_done <= 1'b1;
                rd         <= '0;
                pay_valid  <= 1'b1;
                pay_data   <= mem[0];
                pay_last   <= len == 8'd1;
              end else begin
                state     <= IDLE;
                frame_err <= 1'b1;
                err_code  <= 3'd4;
              end
            end
          OUT: begin
            // bytes arriving while streaming are dropped; the stream itself continues
            if (rx_valid) begin
              frame_err <= 1'b1;
              err_code  <= 3'd6;
            end
            if (pay_valid && pay_ready) begin
              if (pay_last) begin
                state     <= IDLE;
                pay_valid <= 1'b0;
              end else begin
                rd       <= rd + 1'b1;
                pay_data <= mem[rd + 1'b1];
                pay_last <= 8'(rd) + 8'd2 == len;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_check_err = 1'b0, rx_stop_err = 1'b0;
  logic [7:0] pay_data, frame_len;
  logic       pay_valid, pay_last, frame_done, frame_err;
  logic       pay_ready = 1'b0;
  logic [2:0] err_code;
  int errors = 0, checks = 0;
  int n_err, n_done, n_hs, n_pv, stab_bad, lat_bad;
  int last_code;
  logic [7:0] got_d [32];
  logic       got_l [32];
  logic       prev_v, prev_r, prev_l;
  logic [7:0] prev_d;
  always #5 clk = ~clk;
  uart_rx_frame_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_check_err(rx_check_err), .rx_stop_err(rx_stop_err),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_last(pay_last), .pay_ready(pay_ready),
    .frame_len(frame_len), .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
  );
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) begin n_err++; last_code = int'(err_code); end
      if (frame_done) n_done++;
      if (frame_done && !pay_valid) lat_bad++;
      if (pay_valid) n_pv++;
      if (prev_v && !prev_r && !(pay_valid && pay_data == prev_d && pay_last == prev_l)) stab_bad++;
      if (pay_valid && pay_ready && n_hs < 32) begin got_d[n_hs] = pay_data; got_l[n_hs] = pay_last; end
      if (pay_valid && pay_ready) n_hs++;
    end
    prev_v = pay_valid; prev_r = pay_ready; prev_d = pay_data; prev_l = pay_last;
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_err = 0; n_done = 0; n_hs = 0; n_pv = 0; stab_bad = 0; lat_bad = 0; last_code = 0;
  endtask
  task automatic send_e(input logic [7:0] d, input logic ce, input logic se);
    @(posedge clk); #2;
    rx_data = d; rx_valid = 1'b1; rx_check_err = ce; rx_stop_err = se;
    @(posedge clk); #2;
    rx_valid = 1'b0; rx_check_err = 1'b0; rx_stop_err = 1'b0;
  endtask
  task automatic send(input logic [7:0] d);
    send_e(d, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wait_hs(input string tag, input int n);
    for (int i = 0; i < 200 && n_hs < n; i++) @(posedge clk);
    idle(2);
    check(tag, n_hs, n);
  endtask
  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_pay_valid", pay_valid, 0);
    check("rst_pay_data", pay_data, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_err_code", err_code, 0);
    check("rst_pulses", {frame_done, frame_err, pay_last}, 0);
    // good frame, sink always ready
    clr(); pay_ready = 1'b1;
    send(8'hEB); send(8'h90); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    wait_hs("good_hs", 3);
    check("good_done", n_done, 1);
    check("good_len", frame_len, 3);
    check("good_err", n_err, 0);
    check("good_lat", lat_bad, 0);
    check("good_d0", got_d[0], 8'h11);
    check("good_d1", got_d[1], 8'h22);
    check("good_d2", got_d[2], 8'h33);
    check("good_last", {got_l[0], got_l[1], got_l[2]}, 3'b001);
    check("good_idle", pay_valid, 0);
    // backpressure 1-0-0-1
    clr(); pay_ready = 1'b0;
    send(8'hEB); send(8'h90); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    for (int k = 0; k < 60 && n_hs < 3; k++) begin
      @(posedge clk); #2;
      pay_ready = (k % 4 == 0) || (k % 4 == 3);
    end
    idle(4);
    check("bp_hs", n_hs, 3);
    check("bp_stable", stab_bad, 0);
    check("bp_data", {got_d[0], got_d[1], got_d[2]}, 24'h112233);
    check("bp_last", {got_l[0], got_l[1], got_l[2]}, 3'b001);
    check("bp_err", n_err, 0);
    // checksum error
    clr(); pay_ready = 1'b1;
    send(8'hEB); send(8'h90); send(8'h02); send(8'h01); send(8'h02); send(8'h00); idle(3);
    check("csum_err_n", n_err, 1);
    check("csum_err_code", last_code, 4);
    check("csum_no_pv", n_pv + n_done, 0);
    // zero and oversize length
    clr();
    send(8'hEB); send(8'h90); send(8'h00); idle(3);
    check("len0_code", last_code, 3);
    check("len0_n", n_err, 1);
    clr();
    send(8'hEB); send(8'h90); send(8'h11); idle(3);
    check("len17_code", last_code, 3);
    // maximum length frame: 0..15, csum = 0x10 + 0x78
    clr();
    send(8'hEB); send(8'h90); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h88);
    wait_hs("max_hs", 16);
    check("max_len", frame_len, 16);
    check("max_d15", got_d[15], 15);
    check("max_d7", got_d[7], 7);
    check("max_last", {got_l[14], got_l[15]}, 2'b01);
    check("max_err", n_err, 0);
    // stop error mid-frame, then both flags (parity wins)
    clr();
    send(8'hEB); send(8'h90); send(8'h02); send_e(8'h01, 1'b0, 1'b1); idle(3);
    check("stop_code", last_code, 2);
    check("stop_n", n_err, 1);
    clr();
    send(8'hEB); send_e(8'h90, 1'b1, 1'b1); idle(3);
    check("par_code", last_code, 1);
    // bad byte in IDLE is ignored and does not start a frame
    clr();
    send_e(8'hEB, 1'b1, 1'b0); send(8'h90); send(8'h01); send(8'h55); send(8'h56); idle(3);
    check("idle_bad_err", n_err, 0);
    check("idle_bad_done", n_done, 0);
    // resync on repeated header byte
    clr();
    send(8'hEB); send(8'hEB); send(8'h90); send(8'h01); send(8'h55); send(8'h56);
    wait_hs("resync_hs", 1);
    check("resync_d", got_d[0], 8'h55);
    check("resync_last", got_l[0], 1);
    check("resync_done", n_done, 1);
    // overrun while streaming under backpressure
    clr(); pay_ready = 1'b0;
    send(8'hEB); send(8'h90); send(8'h02); send(8'hAA); send(8'hBB); send(8'h67);
    send(8'h77); idle(3);
    check("ovr_code", last_code, 6);
    check("ovr_n", n_err, 1);
    check("ovr_held", {pay_valid, pay_data}, 9'h1AA);
    pay_ready = 1'b1;
    wait_hs("ovr_hs", 2);
    check("ovr_data", {got_d[0], got_d[1]}, 16'hAABB);
    check("ovr_stable", stab_bad, 0);
    // reset mid-frame discards the partial frame
    clr();
    send(8'hEB); send(8'h90); send(8'h02); send(8'h11);
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
    send(8'h22); send(8'h33); idle(3);
    check("rst_mid_done", n_done + n_err, 0);
`ifdef RX_TIMEOUT_EN
    clr();
    send(8'hEB); send(8'h90); idle(100); idle(2);
    check("tmo_code", last_code, 5);
    check("tmo_n", n_err, 1);
    // byte lands on the would-be expiry cycle: it wins
    clr();
    send(8'hEB); send(8'h90);
    repeat (98) @(posedge clk);
    send(8'h01); send(8'h55); send(8'h56);
    wait_hs("tmo_edge_hs", 1);
    check("tmo_edge_err", n_err, 0);
    check("tmo_edge_done", n_done, 1);
`else
    clr();
    send(8'hEB); send(8'h90); idle(150);
    send(8'h01); send(8'h55); send(8'h56);
    wait_hs("no_tmo_hs", 1);
    check("no_tmo_err", n_err, 0);
    check("no_tmo_done", n_done, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
